// File: rtl/rr_pkg.sv
// Shared types for the round-robin request agent.
//   N_PORTS_DEF / DEPTH_DEF / LEN_W_DEF : default sizing of the agent
//   port_state_e                        : per-port requester state
//   job_t                               : one queued burst job
package rr_pkg;

  localparam int unsigned N_PORTS_DEF = 4;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned LEN_W_DEF   = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq
  } port_state_e;

  typedef struct packed {
    logic [LEN_W_DEF-1:0] len;
  } job_t;

endpackage

// File: rtl/rr_job_fifo.sv
// Single-clock synchronous FIFO holding burst lengths for one port.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : write i_data (ignored when full)
//   i_pop        : drop the head entry (ignored when empty)
//   o_data       : head entry
//   o_full       : no free slot
//   o_empty      : no entry
module rr_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/rr_request_agent.sv
// Requester side of a round-robin fixed-time-slice arbiter. Each port queues burst
// jobs and holds its request line until every beat of the current burst has been
// granted; grants may be withdrawn mid-burst.
//   i_clk, i_rst               : clock, synchronous active-high reset
//   i_push_valid/port/len      : job offer; zero-length jobs are accepted and dropped
//   o_push_ready               : selected port's FIFO has room
//   o_req / i_gnt              : request/grant lines to/from the arbiter
//   o_beat_valid/port/last     : registered report of last cycle's granted beat
//   o_done                     : per-port pulse when a burst completes
//   o_grant_err                : sticky flag for stray or non-one-hot grants
module rr_request_agent
  import rr_pkg::*;
#(
  parameter int unsigned N_PORTS = N_PORTS_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF,
  localparam int unsigned PW     = $clog2(N_PORTS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push_valid,
  input  logic [PW-1:0]      i_push_port,
  input  logic [LEN_W-1:0]   i_push_len,
  output logic               o_push_ready,
  output logic [N_PORTS-1:0] o_req,
  input  logic [N_PORTS-1:0] i_gnt,
  output logic               o_beat_valid,
  output logic [PW-1:0]      o_beat_port,
  output logic               o_beat_last,
  output logic [N_PORTS-1:0] o_done,
  output logic               o_grant_err
);

  logic [N_PORTS-1:0] w_full;
  logic [N_PORTS-1:0] w_empty;
  logic [N_PORTS-1:0] w_push;
  logic [N_PORTS-1:0] w_fire;
  logic [N_PORTS-1:0] w_rem_one;
  logic [LEN_W-1:0]   w_head [N_PORTS];
  logic               w_gnt_legal;
  logic               w_gnt_stray;
  logic [PW-1:0]      w_beat_port;
  logic               w_beat_last;
  job_t               w_push_job;

  logic               r_beat_valid;
  logic [PW-1:0]      r_beat_port;
  logic               r_beat_last;
  logic [N_PORTS-1:0] r_done;
  logic               r_grant_err;

  assign w_push_job.len = i_push_len;
  assign o_push_ready   = !w_full[i_push_port];

  // A multi-hot grant is unusable as a whole: nobody fires that cycle.
  assign w_gnt_legal = ((i_gnt & (i_gnt - N_PORTS'(1))) == '0);
  assign w_gnt_stray = |(i_gnt & ~o_req);
  assign w_fire      = w_gnt_legal ? (i_gnt & o_req) : '0;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    port_state_e      r_state;
    port_state_e      w_state_next;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_next;
    logic             r_req;
    logic             w_req_next;
    logic             w_pop;

    assign w_push[g] = i_push_valid && o_push_ready && (i_push_port == PW'(g)) &&
                       (w_push_job.len != '0);
    assign w_rem_one[g] = (r_rem == LEN_W'(1));
    assign o_req[g]     = r_req;

    rr_job_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LEN_W)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push[g]),
      .i_data  (w_push_job.len),
      .i_pop   (w_pop),
      .o_data  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );

    always_comb begin
      w_state_next = r_state;
      w_rem_next   = r_rem;
      w_req_next   = r_req;
      w_pop        = 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_empty[g]) w_state_next = StLoad;
        end
        StLoad: begin
          w_pop        = 1'b1;
          w_rem_next   = w_head[g];
          w_state_next = StReq;
          w_req_next   = 1'b1;
        end
        StReq: begin
          // Un-granted cycles hold everything; the burst resumes on the next grant.
          if (w_fire[g]) begin
            w_rem_next = r_rem - LEN_W'(1);
            if (w_rem_one[g]) begin
              w_state_next = StIdle;
              w_req_next   = 1'b0;
            end
          end
        end
        default: begin
          w_state_next = StIdle;
          w_req_next   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state <= StIdle;
        r_rem   <= '0;
        r_req   <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_rem   <= w_rem_next;
        r_req   <= w_req_next;
      end
    end
  end

  // At most one port fires, so the last match is the only match.
  always_comb begin
    w_beat_port = '0;
    w_beat_last = 1'b0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (w_fire[p]) begin
        w_beat_port = PW'(p);
        w_beat_last = w_rem_one[p];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_valid <= 1'b0;
      r_beat_port  <= '0;
      r_beat_last  <= 1'b0;
      r_done       <= '0;
      r_grant_err  <= 1'b0;
    end else begin
      r_beat_valid <= |w_fire;
      r_beat_port  <= w_beat_port;
      r_beat_last  <= w_beat_last;
      r_done       <= w_fire & w_rem_one;
      r_grant_err  <= r_grant_err | !w_gnt_legal | w_gnt_stray;
    end
  end

  assign o_beat_valid = r_beat_valid;
  assign o_beat_port  = r_beat_port;
  assign o_beat_last  = r_beat_last;
  assign o_done       = r_done;
  assign o_grant_err  = r_grant_err;

endmodule

// File: tb/tb_rr_request_agent.sv
module tb_rr_request_agent;

  localparam int NP    = 4;
  localparam int DEPTH = 4;
  localparam int LW    = 4;
  localparam int PW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          push_valid;
  logic [PW-1:0] push_port;
  logic [LW-1:0] push_len;
  logic          push_ready;
  logic [NP-1:0] req;
  logic [NP-1:0] gnt;
  logic          beat_valid;
  logic [PW-1:0] beat_port;
  logic          beat_last;
  logic [NP-1:0] done;
  logic          grant_err;

  always #5 clk = ~clk;

  rr_request_agent #(
    .N_PORTS (NP),
    .DEPTH   (DEPTH),
    .LEN_W   (LW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_push_valid (push_valid),
    .i_push_port  (push_port),
    .i_push_len   (push_len),
    .o_push_ready (push_ready),
    .o_req        (req),
    .i_gnt        (gnt),
    .o_beat_valid (beat_valid),
    .o_beat_port  (beat_port),
    .o_beat_last  (beat_last),
    .o_done       (done),
    .o_grant_err  (grant_err)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: job queues per port plus a schedule of when each port's next
  // request rises (two edges after it is idle with work queued).
  int            fq [NP][DEPTH];
  int            fcnt [NP];
  bit            m_act [NP];
  int            m_rem [NP];
  int            m_sched [NP];
  logic [NP-1:0] m_req = '0;
  logic [NP-1:0] m_done = '0;
  bit            m_err = 1'b0;
  bit            m_rst_seen = 1'b0;
  int            edge_n = 0;

  typedef struct {
    int port;
    bit last;
  } beat_t;
  beat_t sb[$];

  int  nbeat [NP];
  int  ndone [NP];
  bit  mon_on = 1'b0;
  int  gmode = 0;  // 0 none, 1 lowest requester, 2 random arbiter, 3 manual

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NP-1:0] fire;
    bit            legal;
    bit            acc;
    beat_t         b;
    edge_n++;
    m_rst_seen = rst;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        fcnt[p] = 0; m_act[p] = 0; m_rem[p] = 0; m_sched[p] = -1;
      end
      m_req = '0; m_done = '0; m_err = 0;
      return;
    end
    legal = ($countones(gnt) <= 1);
    acc   = push_valid && (fcnt[push_port] < DEPTH);
    if (!legal || ((gnt & ~m_req) != '0)) m_err = 1;
    fire   = legal ? (gnt & m_req) : '0;
    m_done = '0;
    for (int p = 0; p < NP; p++) begin
      if (fire[p]) begin
        b.port = p; b.last = (m_rem[p] == 1);
        sb.push_back(b);
        m_rem[p]--;
        if (m_rem[p] == 0) begin m_act[p] = 0; m_done[p] = 1'b1; end
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (!m_act[p] && m_sched[p] == edge_n) begin
        m_rem[p] = fq[p][0];
        for (int k = 0; k < DEPTH - 1; k++) fq[p][k] = fq[p][k+1];
        fcnt[p]--;
        m_act[p] = 1; m_sched[p] = -1;
      end
    end
    if (acc && push_len != 0) begin
      fq[push_port][fcnt[push_port]] = int'(push_len);
      fcnt[push_port]++;
    end
    for (int p = 0; p < NP; p++) begin
      if (!m_act[p] && m_sched[p] < 0 && fcnt[p] > 0) m_sched[p] = edge_n + 2;
      m_req[p] = m_act[p];
    end
  endtask

  function automatic logic [NP-1:0] pick(logic [NP-1:0] r, int start);
    for (int i = 0; i < NP; i++) begin
      int p = (start + i) % NP;
      if (r[p]) return NP'(1) << p;
    end
    return '0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    push_valid = 1'b0;
    case (gmode)
      0: gnt = '0;
      1: gnt = pick(m_req, 0);
      2: gnt = ($urandom_range(9) < 7) ? pick(m_req, int'($urandom_range(NP - 1))) : '0;
      default: ;
    endcase
  endtask

  task automatic push(int p, int len);
    push_valid = 1'b1;
    push_port  = PW'(p);
    push_len   = LW'(len);
    cyc();
  endtask

  task automatic wait_dut_req(int p);
    int k = 0;
    while (!req[p] && k < 20) begin cyc(); k++; end
    check("wait_req", int'(req[p]), 1);
  endtask

  // Monitor: per-cycle outputs against the model, beats against the scoreboard.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("req", int'(req), int'(m_req));
        check("push_ready", int'(push_ready), int'(fcnt[push_port] < DEPTH));
        check("grant_err", int'(grant_err), int'(m_err));
        check("done", int'(done), int'(m_done));
        for (int p = 0; p < NP; p++) ndone[p] += int'(done[p]);
        if (beat_valid) begin
          nbeat[beat_port]++;
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL beat_unexpected: got port %0d want no beat at t=%0t", beat_port, $time);
          end else begin
            b = sb.pop_front();
            check("beat_port", int'(beat_port), b.port);
            check("beat_last", int'(beat_last), int'(b.last));
          end
        end else if (sb.size() != 0) begin
          b = sb.pop_front();
          total++; bad++;
          $display("FAIL beat_missing: got none want port %0d at t=%0t", b.port, $time);
        end
        if (m_rst_seen) begin
          check("rst_beat_valid", int'(beat_valid), 0);
          check("rst_beat_port", int'(beat_port), 0);
          check("rst_beat_last", int'(beat_last), 0);
        end
      end
    end
  end

  initial begin
    int b0, d0, s0;
    rst = 1'b1; push_valid = 1'b0; push_port = '0; push_len = '0; gnt = '0;
    for (int p = 0; p < NP; p++) begin m_sched[p] = -1; nbeat[p] = 0; ndone[p] = 0; end
    cyc();
    mon_on = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // 1: single burst, grant follows request
    gmode = 1;
    b0 = nbeat[1]; d0 = ndone[1];
    push(1, 3);
    repeat (8) cyc();
    check("t1_beats", nbeat[1] - b0, 3);
    check("t1_done", ndone[1] - d0, 1);

    // 2: preemption mid-burst
    gmode = 3; gnt = '0;
    b0 = nbeat[2];
    push(2, 4);
    wait_dut_req(2);
    gnt = 4'b0100; cyc(); cyc();
    gnt = 4'b0000; cyc(); cyc(); cyc();
    check("t2_req_held", int'(req[2]), 1);
    gnt = 4'b0100; cyc(); cyc();
    gnt = 4'b0000; repeat (3) cyc();
    check("t2_beats", nbeat[2] - b0, 4);

    // 3: fill port 3 with no grants
    gmode = 0;
    for (int i = 0; i < 5; i++) push(3, 2);
    check("t3_full", int'(push_ready), 0);
    push(3, 2);
    gmode = 1;
    begin
      int k = 0;
      while (!push_ready && k < 20) begin cyc(); k++; end
    end
    check("t3_ready_back", int'(push_ready), 1);
    repeat (30) cyc();

    // 5: back-to-back bursts on port 0
    d0 = ndone[0];
    push(0, 2);
    push(0, 2);
    repeat (12) cyc();
    check("t5_done", ndone[0] - d0, 2);

    // Random traffic with a well-behaved random arbiter
    gmode = 2;
    for (int i = 0; i < 300; i++) begin
      push_port = PW'($urandom_range(NP - 1));
      if ($urandom_range(1) == 1) begin
        push_valid = 1'b1;
        push_len   = LW'($urandom_range(15));
      end
      cyc();
    end
    begin
      int k = 0;
      while (k < 400 && (m_req != '0 || fcnt[0] + fcnt[1] + fcnt[2] + fcnt[3] != 0)) begin
        cyc(); k++;
      end
    end
    cyc();
    check("drain_idle", int'(req), 0);

    // 4: stray grant, then multi-hot grant
    gmode = 3; gnt = '0;
    push(1, 3); push(2, 3); cyc(); cyc();
    push(3, 3);
    s0 = nbeat[0] + nbeat[1] + nbeat[2] + nbeat[3];
    gnt = 4'b1000; cyc();
    check("t4_err_set", int'(grant_err), 1);
    gnt = 4'b0110; cyc();
    gnt = 4'b0000; cyc(); cyc();
    check("t4_no_beat", nbeat[0] + nbeat[1] + nbeat[2] + nbeat[3] - s0, 0);
    check("t4_err_sticky", int'(grant_err), 1);
    gmode = 1;
    repeat (40) cyc();

    // 6: reset mid-burst with a second job queued
    gmode = 3; gnt = '0;
    push(1, 4);
    push(1, 5);
    wait_dut_req(1);
    gnt = 4'b0010; cyc(); cyc();
    gnt = 4'b0000;
    rst = 1'b1; cyc();
    rst = 1'b0;
    check("t6_req_clear", int'(req), 0);
    check("t6_err_clear", int'(grant_err), 0);
    gmode = 1;
    repeat (6) cyc();
    check("t6_stays_idle", int'(req), 0);
    d0 = ndone[1]; b0 = nbeat[1];
    push(1, 2);
    repeat (8) cyc();
    check("t6_restart_beats", nbeat[1] - b0, 2);
    check("t6_restart_done", ndone[1] - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
